wb_regfile: RTL and testbench
=============================

# wb_regfile

Write-back stage and architectural register file for the pipelined LEGv8 core. Consumes the MEM/WB pipeline register outputs, selects the write-back value, and commits it to a 32 x 64-bit register file with X31 hard-wired to zero. Two combinational read ports serve ID, with same-cycle write-through bypass. A committed-write counter gives the bench a retirement check.

## Interface
Parameters:
- DATA_W, 64, register and data width
- CNT_W, 32, width of the committed-write counter

Ports:
- clk  input  1  core clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- RegWrite_In  input  1  from MEM/WB; write-back enable
- MemtoReg_In  input  1  from MEM/WB; 1 selects ReadData_In, 0 selects ALU_result_In
- ReadData_In  input  DATA_W  from MEM/WB; data-memory load value
- ALU_result_In  input  DATA_W  from MEM/WB; ALU result
- RegisterRd_In  input  5  from MEM/WB; destination register
- ReadReg1  input  5  ID read address, port 1 (Rn)
- ReadReg2  input  5  ID read address, port 2 (Rm/Rt)
- ReadData1  output  DATA_W  port 1 read data, combinational
- ReadData2  output  DATA_W  port 2 read data, combinational
- WriteData_Out  output  DATA_W  selected write-back value, combinational, for EX forwarding
- WriteEn_Out  output  1  effective write enable this cycle, combinational
- wb_count  output  CNT_W  number of committed register writes since reset

## Operation
- WriteData_Out = MemtoReg_In ? ReadData_In : ALU_result_In. This is always driven, including during reset.
- WriteEn_Out = rst_n & RegWrite_In & (RegisterRd_In != 31).
- Storage covers X0..X30 only. X31 (XZR) has no storage and always reads 0. Writes addressed to 31 are discarded and are not counted.
- Commit: on a rising clk edge with WriteEn_Out = 1, reg[RegisterRd_In] <= WriteData_Out and wb_count <= wb_count + 1. The counter wraps modulo 2^CNT_W and does not saturate.
- Read port n, evaluated independently for each port:
  - If rst_n = 0: the port returns 0.
  - Else, if ReadRegn = 31: the port returns 0.
  - Else, if WriteEn_Out = 1 and ReadRegn = RegisterRd_In: the port returns WriteData_Out (write-through bypass).
  - Else: the port returns reg[ReadRegn].
- Both ports may address the same register and must return identical values.
- MemtoReg_In has no effect on state when RegWrite_In = 0.

## Timing
- Reset: asserting rst_n low immediately clears reg[0..30] = 0 and wb_count = 0, without waiting for clk. While reset is held, ReadData1 and ReadData2 are 0, WriteEn_Out is 0, and no commit occurs.
- Reset deassertion: the first commit can happen at the first rising edge at which rst_n is already high. If reset is asserted in the middle of a write cycle, that write is lost and the register stays 0.
- Write latency: a value presented in cycle N is stored at the edge ending cycle N. It is visible on the read ports in cycle N through the bypass and from storage in cycle N+1 onward.
- Read latency: zero; the read ports are purely combinational from ReadRegn, storage, and the MEM/WB inputs.
- Back-to-back writes to the same Rd in consecutive cycles: the last write wins, and the bypass always reflects the current-cycle input.
- No handshake: the block accepts one write-back per cycle unconditionally. Stalling is handled upstream by holding or bubbling the MEM/WB register (bubble = RegWrite_In 0).
- wb_count updates on the same edge as the register commit.

## Test plan
- Reset: pre-load X5 = 0x1234, then pulse rst_n low mid-cycle with no clk edge. Required: ReadData1 (ReadReg1=5) = 0 immediately and wb_count = 0. After release, X5 still reads 0.
- Write-back mux and commit: RegWrite=1, MemtoReg=0, ALU_result=0xDEAD_BEEF, ReadData=0x55, Rd=3; then MemtoReg=1, Rd=4, with one edge each. Required: X3 = 0xDEADBEEF, X4 = 0x55, wb_count = 2.
- Bypass: in the same cycle, write Rd=7 with value 0xA5A5, ReadReg1=7, ReadReg2=7, before the edge. Required: both ports = 0xA5A5 before the edge. After the edge, the value is stored and still reads 0xA5A5 with RegWrite=0.
- XZR: RegWrite=1, Rd=31, ALU_result=0xFFFF_FFFF_FFFF_FFFF, then read ReadReg1=31. Required: ReadData1 = 0, WriteEn_Out = 0, wb_count unchanged, and no bypass.
- Disabled write and bubble: RegWrite=0, Rd=9, ALU_result=0x77 for 3 edges. Required: X9 keeps its prior value, there is no bypass on port reading 9, and wb_count is unchanged.
- Counter wrap: with CNT_W=4, perform 17 valid writes. Required: wb_count = 1. Then do a random fill of X0..X30 and read all 31 registers on both ports against a reference model.

Source files
------------

// File: rtl/wb_regfile.sv
// ============================================================================
// wb_regfile : LEGv8 write-back mux and 31 x DATA_W register file (XZR = 0)
// Rev 1.0
// ============================================================================
`default_nettype none

module wb_regfile #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RegWrite_In,
  input  logic              MemtoReg_In,
  input  logic [DATA_W-1:0] ReadData_In,
  input  logic [DATA_W-1:0] ALU_result_In,
  input  logic [4:0]        RegisterRd_In,
  input  logic [4:0]        ReadReg1,
  input  logic [4:0]        ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic [DATA_W-1:0] WriteData_Out,
  output logic              WriteEn_Out,
  output logic [CNT_W-1:0]  wb_count
);

  localparam logic [4:0] XZR = 5'd31;

  logic [DATA_W-1:0] regs [0:30];

  assign WriteData_Out = MemtoReg_In ? ReadData_In : ALU_result_In;
  assign WriteEn_Out   = rst_n & RegWrite_In & (RegisterRd_In != XZR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 31; i++) begin
        regs[i] <= '0;
      end
      wb_count <= '0;
    end else if (WriteEn_Out) begin
      regs[RegisterRd_In] <= WriteData_Out;
      wb_count            <= wb_count + CNT_W'(1);
    end
  end

  // Same-cycle write is bypassed so ID sees the value being retired now.
  function automatic logic [DATA_W-1:0] read_port(input logic [4:0] addr);
    logic [DATA_W-1:0] val;
    val = '0;
    if (rst_n && addr != XZR) begin
      if (WriteEn_Out && addr == RegisterRd_In) begin
        val = WriteData_Out;
      end else begin
        val = regs[addr];
      end
    end
    return val;
  endfunction

  always_comb begin
    ReadData1 = read_port(ReadReg1);
    ReadData2 = read_port(ReadReg2);
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_regfile.sv
// ============================================================================
// tb_wb_regfile : directed self-checking bench for wb_regfile (CNT_W = 4)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_wb_regfile;

  localparam int DW = 64;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          RegWrite_In;
  logic          MemtoReg_In;
  logic [DW-1:0] ReadData_In;
  logic [DW-1:0] ALU_result_In;
  logic [4:0]    RegisterRd_In;
  logic [4:0]    ReadReg1;
  logic [4:0]    ReadReg2;
  logic [DW-1:0] ReadData1;
  logic [DW-1:0] ReadData2;
  logic [DW-1:0] WriteData_Out;
  logic          WriteEn_Out;
  logic [CW-1:0] wb_count;

  wb_regfile #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .RegWrite_In   (RegWrite_In),
    .MemtoReg_In   (MemtoReg_In),
    .ReadData_In   (ReadData_In),
    .ALU_result_In (ALU_result_In),
    .RegisterRd_In (RegisterRd_In),
    .ReadReg1      (ReadReg1),
    .ReadReg2      (ReadReg2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2),
    .WriteData_Out (WriteData_Out),
    .WriteEn_Out   (WriteEn_Out),
    .wb_count      (wb_count)
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [DW-1:0] model [0:31];
  int            exp_cnt;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = '0;
    exp_cnt = 0;
  endtask

  // Present a write-back and check the combinational mux / enable before the edge.
  task automatic drive_wb(input logic [4:0] rd, input logic [DW-1:0] alu,
                          input logic [DW-1:0] mem, input logic m2r);
    RegWrite_In   = 1'b1;
    MemtoReg_In   = m2r;
    ALU_result_In = alu;
    ReadData_In   = mem;
    RegisterRd_In = rd;
    #1;
    check("wdata_mux", WriteData_Out, m2r ? mem : alu);
    check("wen", {63'd0, WriteEn_Out}, {63'd0, rd != 5'd31});
  endtask

  task automatic clock_wb();
    @(posedge clk);
    #1;
    if (RegWrite_In && RegisterRd_In != 5'd31) begin
      model[RegisterRd_In] = MemtoReg_In ? ReadData_In : ALU_result_In;
      exp_cnt = (exp_cnt + 1) % 16;
    end
    RegWrite_In = 1'b0;
  endtask

  task automatic commit(input logic [4:0] rd, input logic [DW-1:0] alu,
                        input logic [DW-1:0] mem, input logic m2r);
    drive_wb(rd, alu, mem, m2r);
    clock_wb();
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    clear_model();
  endtask

  initial begin
    clear_model();
    rst_n = 1'b0; RegWrite_In = 1'b0; MemtoReg_In = 1'b0;
    ReadData_In = '0; ALU_result_In = '0; RegisterRd_In = '0;
    ReadReg1 = '0; ReadReg2 = '0;

    // Reset held: no enable, no commit, reads zero, mux still live
    #12;
    RegWrite_In = 1'b1; RegisterRd_In = 5'd2; ALU_result_In = 64'hABCD; ReadReg1 = 5'd2;
    #1;
    check("rst_count", {60'd0, wb_count}, 64'd0);
    check("rst_wen", {63'd0, WriteEn_Out}, 64'd0);
    check("rst_rd1", ReadData1, 64'd0);
    check("rst_wdata", WriteData_Out, 64'hABCD);
    @(posedge clk); #1;
    RegWrite_In = 1'b0;
    rst_n = 1'b1;
    #1;
    check("no_commit_in_rst", ReadData1, 64'd0);

    // Asynchronous reset clears a stored register without a clock edge
    commit(5'd5, 64'h1234, 64'h0, 1'b0);
    ReadReg1 = 5'd5; #1;
    check("preload_x5", ReadData1, 64'h1234);
    check("preload_cnt", {60'd0, wb_count}, 64'd1);
    rst_n = 1'b0; #1;
    check("async_rd1", ReadData1, 64'd0);
    check("async_cnt", {60'd0, wb_count}, 64'd0);
    rst_n = 1'b1; clear_model(); #1;
    check("post_rst_x5", ReadData1, 64'd0);

    // Write-back mux and commit
    commit(5'd3, 64'hDEAD_BEEF, 64'h55, 1'b0);
    commit(5'd4, 64'hDEAD_BEEF, 64'h55, 1'b1);
    ReadReg1 = 5'd3; ReadReg2 = 5'd4; #1;
    check("x3_alu", ReadData1, 64'hDEAD_BEEF);
    check("x4_mem", ReadData2, 64'h55);
    check("cnt_2", {60'd0, wb_count}, 64'd2);

    // Bypass on both ports, then stored value
    ReadReg1 = 5'd7; ReadReg2 = 5'd7;
    drive_wb(5'd7, 64'hA5A5, 64'h0, 1'b0);
    check("byp_rd1", ReadData1, 64'hA5A5);
    check("byp_rd2", ReadData2, 64'hA5A5);
    clock_wb(); #1;
    check("stored_rd1", ReadData1, 64'hA5A5);
    check("stored_rd2", ReadData2, 64'hA5A5);
    check("cnt_3", {60'd0, wb_count}, 64'd3);

    // XZR write discarded, not bypassed, not counted
    ReadReg1 = 5'd31; ReadReg2 = 5'd31;
    drive_wb(5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0);
    check("xzr_byp", ReadData1, 64'd0);
    clock_wb(); #1;
    check("xzr_rd1", ReadData1, 64'd0);
    check("xzr_cnt", {60'd0, wb_count}, 64'd3);

    // Bubble: RegWrite low with Rd = 9 for three edges
    commit(5'd9, 64'h1111, 64'h0, 1'b0);
    ReadReg1 = 5'd9; RegisterRd_In = 5'd9; ALU_result_In = 64'h77; MemtoReg_In = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bubble_wen", {63'd0, WriteEn_Out}, 64'd0);
      check("bubble_x9", ReadData1, 64'h1111);
      @(posedge clk); #1;
    end
    check("bubble_cnt", {60'd0, wb_count}, 64'd4);

    // Counter wrap: 17 writes modulo 16
    reset_pulse();
    for (int k = 0; k < 17; k++) commit(5'(k % 31), 64'(k + 1), 64'h0, 1'b0);
    check("cnt_wrap", {60'd0, wb_count}, 64'd1);

    // Random fill, then sweep both ports against the model
    for (int r = 0; r < 31; r++) begin
      commit(5'(r), {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    end
    for (int r = 0; r < 32; r++) begin
      ReadReg1 = 5'(r); ReadReg2 = 5'(31 - r); #1;
      check($sformatf("sweep1_x%0d", r), ReadData1, model[r]);
      check($sformatf("sweep2_x%0d", 31 - r), ReadData2, model[31 - r]);
    end
    check("final_cnt", {60'd0, wb_count}, 64'(exp_cnt));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
